// File: rtl/mat_vec_loader.sv
// ============================================================================
// mat_vec_loader
// ----------------------------------------------------------------------------
// Upstream loader for mat_vec_mult. Fetches a DEPTH x DEPTH matrix and a
// DEPTH x 1 vector from word-addressed memory and fills the A/B FIFOs.
//   - Words base+0 .. base+DEPTH-1 are matrix slices; each is written to all
//     A FIFOs as a single a_wren beat (element i -> FIFO i).
//   - Word base+DEPTH is the vector; it is serialised over DEPTH b_wren beats,
//     element 0 first.
// Address arithmetic wraps modulo 2^ADDR_WIDTH. One read outstanding at a time.
//
// Build option:
//   MVL_CLR_EN  defined  : clr pulses for one cycle right after start is
//                          accepted, clearing the MAC accumulators.
//               undefined: clr is tied low.
//
// Ports:
//   clk               in   single clock, posedge
//   rst_n             in   synchronous active-low reset
//   start             in   load request, sampled in IDLE only
//   base_addr         in   first word address, captured on start
//   busy              out  high in every state except IDLE
//   done              out  one-cycle pulse when the load completes
//   clr               out  MAC clear pulse (MVL_CLR_EN only)
//   mem_address       out  read word address (0 when not reading)
//   mem_read          out  read request
//   mem_waitrequest   in   slave stall; request held while high
//   mem_readdata      in   read data, DEPTH*DATA_WIDTH bits
//   mem_readdatavalid in   read data valid
//   a_wren            out  A FIFO write strobe (all DEPTH FIFOs)
//   a_fifo_in         out  DEPTH elements of DATA_WIDTH, one per A FIFO
//   b_wren            out  B FIFO write strobe
//   b_fifo_in         out  vector element
// ============================================================================
module mat_vec_loader #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [ADDR_WIDTH-1:0]                 base_addr,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  clr,
    output logic [ADDR_WIDTH-1:0]                 mem_address,
    output logic                                  mem_read,
    input  logic                                  mem_waitrequest,
    input  logic [DEPTH*DATA_WIDTH-1:0]           mem_readdata,
    input  logic                                  mem_readdatavalid,
    output logic                                  a_wren,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0]      a_fifo_in,
    output logic                                  b_wren,
    output logic [DATA_WIDTH-1:0]                 b_fifo_in
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_A_REQ   = 3'd1;
    localparam logic [2:0] S_A_WAIT  = 3'd2;
    localparam logic [2:0] S_B_REQ   = 3'd3;
    localparam logic [2:0] S_B_WAIT  = 3'd4;
    localparam logic [2:0] S_B_SHIFT = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]                          r_state;
    logic [ADDR_WIDTH-1:0]               r_base;
    // Row index during A reads, beat index during B_SHIFT.
    logic [CNT_W-1:0]                    r_cnt;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]    r_a_data;
    logic                                r_a_wren;
    logic [DEPTH*DATA_WIDTH-1:0]         r_shift;
`ifdef MVL_CLR_EN
    logic                                r_clr;
`endif

    logic                                w_reading;
    logic [ADDR_WIDTH-1:0]               w_offset;
    logic [ADDR_WIDTH-1:0]               w_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_cnt    <= '0;
            r_a_data <= '0;
            r_a_wren <= 1'b0;
            r_shift  <= '0;
`ifdef MVL_CLR_EN
            r_clr    <= 1'b0;
`endif
        end else begin
            r_a_wren <= 1'b0;
`ifdef MVL_CLR_EN
            r_clr    <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_cnt   <= '0;
                        r_state <= S_A_REQ;
`ifdef MVL_CLR_EN
                        r_clr   <= 1'b1;
`endif
                    end
                end
                S_A_REQ: begin
                    if (!mem_waitrequest) begin
                        r_state <= S_A_WAIT;
                    end
                end
                S_A_WAIT: begin
                    if (mem_readdatavalid) begin
                        r_a_data <= mem_readdata;
                        r_a_wren <= 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            // Counter is reused as the B beat index.
                            r_cnt   <= '0;
                            r_state <= S_B_REQ;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_A_REQ;
                        end
                    end
                end
                S_B_REQ: begin
                    if (!mem_waitrequest) begin
                        r_state <= S_B_WAIT;
                    end
                end
                S_B_WAIT: begin
                    if (mem_readdatavalid) begin
                        r_shift <= mem_readdata;
                        r_cnt   <= '0;
                        r_state <= S_B_SHIFT;
                    end
                end
                S_B_SHIFT: begin
                    // Element 0 sits in the low bits; shift down one element per beat.
                    r_shift <= r_shift >> DATA_WIDTH;
                    if (r_cnt == LAST_CNT) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_reading   = (r_state == S_A_REQ) || (r_state == S_B_REQ);
    assign w_offset    = (r_state == S_B_REQ) ? ADDR_WIDTH'(DEPTH) : ADDR_WIDTH'(r_cnt);
    assign w_addr      = r_base + w_offset;

    assign mem_read    = w_reading;
    assign mem_address = w_reading ? w_addr : '0;

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign a_wren      = r_a_wren;
    assign a_fifo_in   = r_a_data;
    assign b_wren      = (r_state == S_B_SHIFT);
    assign b_fifo_in   = r_shift[DATA_WIDTH-1:0];

`ifdef MVL_CLR_EN
    assign clr         = r_clr;
`else
    assign clr         = 1'b0;
`endif

endmodule

// File: tb/tb_mat_vec_loader.sv
// ============================================================================
// tb_mat_vec_loader
// ----------------------------------------------------------------------------
// Scoreboard bench for mat_vec_loader. Stimulus pushes expected read
// addresses, A words, B elements and done cycles into queues; a monitor pops
// and compares whenever the DUT presents the corresponding output.
// Cycle numbers are relative to the cycle in which start is sampled (cycle 0).
// ============================================================================
module tb_mat_vec_loader;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AW    = 16;
`ifdef MVL_CLR_EN
    localparam logic CLR_EN = 1'b1;
`else
    localparam logic CLR_EN = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          start = 1'b0;
    logic [AW-1:0]                 base_addr = '0;
    logic                          busy, done, clr;
    logic [AW-1:0]                 mem_address;
    logic                          mem_read;
    logic                          mem_waitrequest = 1'b0;
    logic [DEPTH*DW-1:0]           mem_readdata = '0;
    logic                          mem_readdatavalid = 1'b0;
    logic                          a_wren;
    logic [DEPTH-1:0][DW-1:0]      a_fifo_in;
    logic                          b_wren;
    logic [DW-1:0]                 b_fifo_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    logic [63:0] exp_a[$];
    logic [7:0]  exp_b[$];
    logic [15:0] exp_addr[$];
    int          exp_done[$];

    logic        force_valid = 1'b0;
    logic        vec_ovr = 1'b0;
    logic [15:0] vec_addr = '0;
    logic        stall_en = 1'b0;

    mat_vec_loader #(
        .DEPTH(DEPTH),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .busy(busy),
        .done(done),
        .clr(clr),
        .mem_address(mem_address),
        .mem_read(mem_read),
        .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid),
        .a_wren(a_wren),
        .a_fifo_in(a_fifo_in),
        .b_wren(b_wren),
        .b_fifo_in(b_fifo_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - start_cyc);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [15:0] a);
        if (vec_ovr && a == vec_addr) return 64'h0807060504030201;
        return {8{a[7:0]}};
    endfunction

    // Memory: read accepted in cycle n returns data in cycle n+1.
    // Optional stall holds waitrequest high in cycles 5..7 (row 2 request).
    initial begin : mem_model
        logic        acc;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            acc = mem_read && !mem_waitrequest;
            a   = mem_address;
            @(posedge clk);
            #1;
            mem_readdatavalid = acc || force_valid;
            mem_readdata      = (acc || force_valid) ? mem_word(a) : '0;
            mem_waitrequest   = stall_en && (cyc - start_cyc >= 5) && (cyc - start_cyc <= 7);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (a_wren) begin
            if (exp_a.size() == 0) chk("a_unexpected", a_wren, 0);
            else                   chk("a_word", a_fifo_in, exp_a.pop_front());
        end
        if (b_wren) begin
            if (exp_b.size() == 0) chk("b_unexpected", b_wren, 0);
            else                   chk("b_elem", b_fifo_in, exp_b.pop_front());
        end
        if (mem_read && !mem_waitrequest) begin
            if (exp_addr.size() == 0) chk("read_unexpected", mem_read, 0);
            else                      chk("read_addr", mem_address, exp_addr.pop_front());
        end
        if (done) begin
            if (exp_done.size() == 0) chk("done_unexpected", done, 0);
            else                      chk("done_cycle", 64'(cyc - start_cyc), 64'(exp_done.pop_front()));
        end
    end

    task automatic push_load(input logic [15:0] base, input logic vec_custom, input int done_cyc);
        logic [15:0] a;
        for (int k = 0; k < DEPTH; k++) begin
            a = base + 16'(k);
            exp_addr.push_back(a);
            exp_a.push_back({8{a[7:0]}});
        end
        a = base + 16'd8;
        exp_addr.push_back(a);
        for (int k = 0; k < DEPTH; k++) exp_b.push_back(vec_custom ? 8'(k + 1) : a[7:0]);
        exp_done.push_back(done_cyc);
    endtask

    task automatic go(input logic [15:0] base);
        @(posedge clk);
        #1;
        base_addr = base;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        chk("busy_c0", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic to_cycle(input int n);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cyc - start_cyc >= n) break;
        end
    endtask

    task automatic drain();
        chk("q_addr_left", 64'(exp_addr.size()), 0);
        chk("q_a_left",    64'(exp_a.size()), 0);
        chk("q_b_left",    64'(exp_b.size()), 0);
        chk("q_done_left", 64'(exp_done.size()), 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {busy, done, clr, mem_read, a_wren, b_wren, mem_address, b_fifo_in}, 0);
        chk({name, "_afifo"}, a_fifo_in, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_out");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic load, base 0: word k = {8{k}}, vector = {8{08}}, done at 27.
        push_load(16'h0000, 1'b0, 27);
        go(16'h0000);
        to_cycle(1);
        chk("busy_c1", busy, 1);
        chk("clr_c1", clr, CLR_EN);
        to_cycle(2);
        chk("clr_c2", clr, 0);
        to_cycle(27);
        chk("busy_c27", busy, 1);
        to_cycle(28);
        chk("busy_c28", busy, 0);
        to_cycle(32);
        drain();

        // Vector element order: word 0x28 = 0807060504030201 -> 01..08.
        vec_ovr  = 1'b1;
        vec_addr = 16'h0028;
        push_load(16'h0020, 1'b1, 27);
        go(16'h0020);
        to_cycle(32);
        drain();
        vec_ovr = 1'b0;

        // Waitrequest high for 3 cycles on row 2: request held, done at 30.
        stall_en = 1'b1;
        push_load(16'h0040, 1'b0, 30);
        go(16'h0040);
        for (int c = 5; c <= 7; c++) begin
            to_cycle(c);
            chk("stall_read", mem_read, 1);
            chk("stall_addr", mem_address, 16'h0042);
        end
        to_cycle(35);
        drain();
        stall_en = 1'b0;

        // start during B_SHIFT is ignored.
        push_load(16'h0060, 1'b0, 27);
        go(16'h0060);
        to_cycle(20);
        base_addr = 16'h1234;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        to_cycle(40);
        chk("busy_after_ignored_start", busy, 0);
        drain();

        // Reset in cycle 10 (A_WAIT row 4), stray readdatavalid in cycle 11.
        for (int k = 0; k < 5; k++) exp_addr.push_back(16'h0080 + 16'(k));
        for (int k = 0; k < 4; k++) exp_a.push_back({8{8'(8'h80 + k)}});
        go(16'h0080);
        to_cycle(9);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        force_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n       = 1'b1;
        force_valid = 1'b0;
        to_cycle(11);
        chk_all_zero("midreset_out");
        to_cycle(20);
        drain();

        // New load after the aborted one completes normally.
        push_load(16'h0000, 1'b0, 27);
        go(16'h0000);
        to_cycle(32);
        drain();

        // Address wrap: FFFC..FFFF, 0000..0003, vector at 0004.
        push_load(16'hFFFC, 1'b0, 27);
        go(16'hFFFC);
        to_cycle(1);
        chk("clr_wrap_c1", clr, CLR_EN);
        to_cycle(2);
        chk("clr_wrap_c2", clr, 0);
        to_cycle(32);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
